systolic_result_drain: RTL and testbench
========================================

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001: Parameter N SHALL default to 4; it is the array dimension, giving an N x N result matrix.
REQ-002: Parameter BITWIDTH SHALL default to 8; it is the operand width, and each result element is 2*BITWIDTH bits.
REQ-003: Parameter LATENCY SHALL default to 3*N-2; it is the number of cycles from start to a valid array result, and SHALL be at least 1.
REQ-004: Port clk SHALL be input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005: Port reset SHALL be input, 1 bit: synchronous, active-low reset.
REQ-006: Port start SHALL be input, 1 bit: a one-cycle pulse marking that operand feeding into the array has begun.
REQ-007: Port iRes SHALL be input, N*N*2*BITWIDTH bits: the flat result bus from the array. Element (i,j) occupies iRes[((N*N-i*N-j)*2*BITWIDTH-1) -: 2*BITWIDTH], so element (0,0) is in the top slice.
REQ-008: Port oData SHALL be output, 2*BITWIDTH bits: the current result element.
REQ-009: Port oValid SHALL be output, 1 bit: oData is valid.
REQ-010: Port iReady SHALL be input, 1 bit: the downstream block accepts oData.
REQ-011: Port oRow SHALL be output, $clog2(N) bits, and port oCol SHALL be output, $clog2(N) bits: the row and column index of oData.
REQ-012: Port oLast SHALL be output, 1 bit: high together with oValid for element (N-1,N-1).
REQ-013: Port busy SHALL be output, 1 bit, and port done SHALL be output, 1 bit: busy means the block is not IDLE; done is a one-cycle completion pulse.

Function
REQ-014: The FSM SHALL have the states IDLE, WAIT, STREAM and DONE.
REQ-015: In IDLE, when start=1 at a rising edge, the FSM SHALL move to WAIT and clear the wait counter to 0; in any other state, start SHALL be ignored.
REQ-016: In WAIT, the counter SHALL increment each cycle; on the edge where counter==LATENCY-1, iRes SHALL be captured into an internal N*N buffer, the element index SHALL be set to 0, and the FSM SHALL move to STREAM.
REQ-017: iRes is sampled only at that capture edge; changes to iRes at any other time SHALL have no effect.
REQ-018: In STREAM, oValid SHALL be 1, and oData, oRow and oCol SHALL reflect the buffered element at the current index, in row-major order: index = oRow*N + oCol.
REQ-019: A transfer SHALL occur on an edge where oValid=1 and iReady=1; the index SHALL advance only on a transfer.
REQ-020: oData, oRow, oCol and oLast SHALL hold stable while oValid=1 and iReady=0.
REQ-021: The transfer of index N*N-1 SHALL move the FSM to DONE; in DONE, oValid SHALL be 0 and done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-022: A start pulse coincident with done SHALL be ignored; the earliest accepted start is in the cycle after done.
REQ-023: Given iReady held at 1, the first oValid SHALL appear the cycle after capture; the element count is N*N cycles, and done follows the final transfer by one cycle.
REQ-024: oValid SHALL never assert outside STREAM, and oValid SHALL not depend combinationally on iReady.

Reset
REQ-025: While reset=0 at a rising edge, the FSM SHALL go to IDLE and the counter and index SHALL clear to 0.
REQ-026: The reset values SHALL be oValid=0, oData=0, oRow=0, oCol=0, oLast=0, busy=0 and done=0.
REQ-027: Reset asserted in any state, including mid-STREAM with a transfer pending, SHALL abort the operation without producing a done pulse; the internal buffer contents need not be cleared.

Configuration
REQ-028: When macro DRAIN_PARITY_EN is defined, the block SHALL add output port oParity, 1 bit, equal to the XOR of all oData bits; it SHALL be 0 when oValid=0 and 0 on reset, and it follows the same hold rule as oData.
REQ-029: When DRAIN_PARITY_EN is not defined, oParity and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030: Basic drain. Set N=4, BITWIDTH=8, LATENCY=10, element (i,j)=16'h0100*i+j, iReady=1, and pulse start at cycle 0. Required: capture at edge 10, then 16 beats 0000,0001,...,0303 on consecutive cycles, oLast on beat 16, and a done pulse one cycle later.
REQ-031: Backpressure. Hold iReady=0 for 3 cycles at index 5. Required: oData=0101, oRow=1 and oCol=1 held stable, with no skipped or repeated elements.
REQ-032: Late iRes change. Change iRes to all-FFFF after the capture edge. Required: the streamed values are still the captured pattern.
REQ-033: Start while busy. Pulse start during WAIT and again during STREAM. Required: no restart, and the counter and index are unaffected.
REQ-034: Reset mid-STREAM. Drive reset=0 for 1 cycle at index 7. Required: all outputs are 0 on the next cycle, no done pulse, and a fresh start drains from index 0.
REQ-035: Parity check. With DRAIN_PARITY_EN defined and element value 0x0007, oParity SHALL be 1; with value 0x0003, oParity SHALL be 0.

Source files
------------

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Waits LATENCY cycles after a start pulse, snapshots the N x N result matrix
// from the systolic array, then streams it out row-major over a valid/ready
// handshake, finishing with a one-cycle done pulse.
// Optional feature: define DRAIN_PARITY_EN to add the oParity output.
module systolic_result_drain #(
  parameter int N        = 4,
  parameter int BITWIDTH = 8,
  parameter int LATENCY  = 3*N-2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [N*N*2*BITWIDTH-1:0]   iRes,
  output logic [2*BITWIDTH-1:0]       oData,
  output logic                        oValid,
  input  logic                        iReady,
  output logic [$clog2(N)-1:0]        oRow,
  output logic [$clog2(N)-1:0]        oCol,
  output logic                        oLast,
  output logic                        busy,
  output logic                        done
`ifdef DRAIN_PARITY_EN
  ,
  output logic                        oParity
`endif
);

  localparam int W  = 2*BITWIDTH;
  localparam int IW = $clog2(N);
  // Counter only needs to reach LATENCY-1; keep at least one bit for LATENCY=1.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   row_q, row_d;
  logic [IW-1:0]   col_q, col_d;
  logic            capture;
  logic [W-1:0]    buf_q [N][N];

  // Next-state logic: wait for the array, capture once, then walk row-major on transfers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Index only moves on a handshake, so outputs hold under backpressure.
        if (iReady) begin
          if (col_q == IDX_LAST) begin
            col_d = '0;
            if (row_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, wait counter and element index; synchronous active-low reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Snapshot the whole result bus on the capture edge only; (0,0) lives in the top slice.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          buf_q[i][j] <= iRes[(N*N - i*N - j)*W - 1 -: W];
        end
      end
    end
  end

  // Output decode: everything is zero outside STREAM; valid never looks at iReady.
  always_comb begin
    oValid = (state_q == STREAM);
    oData  = '0;
    oRow   = '0;
    oCol   = '0;
    oLast  = 1'b0;
    if (state_q == STREAM) begin
      oData = buf_q[row_q][col_q];
      oRow  = row_q;
      oCol  = col_q;
      oLast = (row_q == IDX_LAST) && (col_q == IDX_LAST);
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

`ifdef DRAIN_PARITY_EN
  // oData is already zero when not valid, so parity is zero there too.
  assign oParity = ^oData;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain.
// Expected beats are pushed to a scoreboard when a matrix is driven and
// popped/compared as the DUT streams them out.
`timescale 1ns/1ps
module tb_systolic_result_drain;

  localparam int N   = 4;
  localparam int BW  = 8;
  localparam int W   = 2*BW;
  localparam int LAT = 10;
  localparam int IW  = $clog2(N);

  logic            clk    = 1'b0;
  logic            reset  = 1'b0;
  logic            start  = 1'b0;
  logic            iReady = 1'b1;
  logic [N*N*W-1:0] iRes  = '0;
  logic [W-1:0]    oData;
  logic            oValid;
  logic            oLast;
  logic            busy;
  logic            done;
  logic [IW-1:0]   oRow;
  logic [IW-1:0]   oCol;
`ifdef DRAIN_PARITY_EN
  logic            oParity;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [W-1:0]  data;
    logic          last;
  } beat_t;

  beat_t        sb[$];
  logic [W-1:0] mat [N][N];

  always #5 clk = ~clk;

  systolic_result_drain #(
    .N(N),
    .BITWIDTH(BW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .iRes(iRes),
    .oData(oData),
    .oValid(oValid),
    .iReady(iReady),
    .oRow(oRow),
    .oCol(oCol),
    .oLast(oLast),
    .busy(busy),
    .done(done)
`ifdef DRAIN_PARITY_EN
    ,
    .oParity(oParity)
`endif
  );

  // Place mat onto the flat bus, element (0,0) in the top slice.
  task automatic drive_matrix();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        iRes[(N*N - i*N - j)*W - 1 -: W] = mat[i][j];
      end
    end
  endtask

  // Scoreboard producer: the row-major beats the DUT must stream for mat.
  task automatic push_expected();
    beat_t b;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        b.row  = IW'(i);
        b.col  = IW'(j);
        b.data = mat[i][j];
        b.last = (i == N-1) && (j == N-1);
        sb.push_back(b);
      end
    end
  endtask

  // Pulse start (edge 0), run to the edge before capture, sample, then step over the capture edge.
  task automatic start_and_wait(input int restart_at, output logic pre_valid, output logic pre_busy);
    drive_matrix();
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      start = (c == restart_at);
      @(negedge clk);
    end
    start     = 1'b0;
    pre_valid = oValid;
    pre_busy  = busy;
    @(negedge clk);
  endtask

  // Scoreboard consumer: compare the front beat every cycle, pop on a handshake.
  task automatic drain(input int stall_at, input int stall_len, input int start_at, input int stop_at);
    int    stalled = 0;
    int    guard   = 0;
    int    idx;
    bit    pulsed  = 0;
    beat_t e;
    while (sb.size() > 0 && guard < 4*N*N + 20) begin
      idx = N*N - sb.size();
      if (idx == stop_at) return;
      e = sb[0];
      if (idx == stall_at && stalled < stall_len) begin
        iReady = 1'b0;
        stalled++;
      end else begin
        iReady = 1'b1;
      end
      if (idx == start_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end
      tests_run++;
      if (oValid !== 1'b1 || oData !== e.data || oRow !== e.row || oCol !== e.col || oLast !== e.last) begin
        tests_failed++;
        $display("FAIL beat%0d: got v=%b d=%h r=%0d c=%0d l=%b, want v=1 d=%h r=%0d c=%0d l=%b",
                 idx, oValid, oData, oRow, oCol, oLast, e.data, e.row, e.col, e.last);
      end else begin
        $display("[TB] beat %0d r=%0d c=%0d data=%h last=%b ready=%b", idx, oRow, oCol, oData, oLast, iReady);
      end
`ifdef DRAIN_PARITY_EN
      tests_run++;
      if (oParity !== (^e.data)) begin
        tests_failed++;
        $display("FAIL parity beat%0d: got %b want %b", idx, oParity, ^e.data);
      end
`endif
      if (iReady) void'(sb.pop_front());
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d beats left, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    start  = 1'b1;
    iReady = 1'b1;
    iRes   = {N*N{16'hBEEF}};
    repeat (3) @(negedge clk);
    tests_run += 7;
    if (oValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", oValid); end
    if (oData !== '0)    begin tests_failed++; $display("FAIL reset_data: got %h want 0", oData); end
    if (oRow !== '0)     begin tests_failed++; $display("FAIL reset_row: got %0d want 0", oRow); end
    if (oCol !== '0)     begin tests_failed++; $display("FAIL reset_col: got %0d want 0", oCol); end
    if (oLast !== 1'b0)  begin tests_failed++; $display("FAIL reset_last: got %b want 0", oLast); end
    if (busy !== 1'b0)   begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)   begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef DRAIN_PARITY_EN
    tests_run++;
    if (oParity !== 1'b0) begin tests_failed++; $display("FAIL reset_parity: got %b want 0", oParity); end
`endif
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: busy got %b want 0", busy); end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic_drain();
    logic pv, pb;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = W'(16'h0100*i + j);
    start_and_wait(-1, pv, pb);
    tests_run += 2;
    if (pv !== 1'b0) begin tests_failed++; $display("FAIL early_valid: got %b want 0 before capture", pv); end
    if (pb !== 1'b1) begin tests_failed++; $display("FAIL wait_busy: got %b want 1", pb); end
    drain(-1, 0, -1, -1);
    tests_run += 2;
    if (done !== 1'b1)   begin tests_failed++; $display("FAIL done_pulse: got %b want 1", done); end
    if (oValid !== 1'b0) begin tests_failed++; $display("FAIL valid_in_done: got %b want 0", oValid); end
    // start coincident with done must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run += 2;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL done_width: got %b want 0", done); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_at_done: busy got %b want 0", busy); end
    $display("[TB] basic drain complete");
  endtask

  task automatic test_backpressure();
    logic pv, pb;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = W'(16'h0100*i + j);
    start_and_wait(-1, pv, pb);
    // iRes changes after the capture edge must not reach the stream
    iRes = '1;
    // stall 3 cycles at index 5, and a stray start at index 3 while streaming
    drain(5, 3, 3, -1);
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL bp_done: got %b want 1", done); end
    @(negedge clk);
    $display("[TB] backpressure and late iRes complete");
  endtask

  task automatic test_start_while_busy();
    logic pv, pb;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = W'($urandom_range(0, 16'hFFFF));
    start_and_wait(4, pv, pb);
    tests_run++;
    if (pv !== 1'b0) begin tests_failed++; $display("FAIL wait_restart_valid: got %b want 0", pv); end
    drain(-1, 0, 9, -1);
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL busy_start_done: got %b want 1", done); end
    @(negedge clk);
    $display("[TB] start while busy complete");
  endtask

  task automatic test_reset_mid_stream();
    logic pv, pb;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = W'(16'h0100*i + j) ^ 16'h5A00;
    start_and_wait(-1, pv, pb);
    drain(-1, 0, -1, 7);
    iReady = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    tests_run += 7;
    if (oValid !== 1'b0) begin tests_failed++; $display("FAIL abort_valid: got %b want 0", oValid); end
    if (oData !== '0)    begin tests_failed++; $display("FAIL abort_data: got %h want 0", oData); end
    if (oRow !== '0)     begin tests_failed++; $display("FAIL abort_row: got %0d want 0", oRow); end
    if (oCol !== '0)     begin tests_failed++; $display("FAIL abort_col: got %0d want 0", oCol); end
    if (oLast !== 1'b0)  begin tests_failed++; $display("FAIL abort_last: got %b want 0", oLast); end
    if (busy !== 1'b0)   begin tests_failed++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (done !== 1'b0)   begin tests_failed++; $display("FAIL abort_done: got %b want 0", done); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL abort_no_done: got %b want 0", done); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = W'(16'hA000 + i*N + j);
    start_and_wait(-1, pv, pb);
    drain(-1, 0, -1, -1);
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL fresh_done: got %b want 1", done); end
    @(negedge clk);
    $display("[TB] reset mid-stream complete");
  endtask

  task automatic test_parity();
`ifdef DRAIN_PARITY_EN
    logic pv, pb;
    tests_run++;
    if (oParity !== 1'b0) begin tests_failed++; $display("FAIL idle_parity: got %b want 0", oParity); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = ((i*N + j) % 2 == 0) ? 16'h0007 : 16'h0003;
    start_and_wait(-1, pv, pb);
    tests_run += 2;
    if (oParity !== 1'b1) begin tests_failed++; $display("FAIL parity_0007: got %b want 1", oParity); end
    iReady = 1'b1;
    @(negedge clk);
    if (oParity !== 1'b0) begin tests_failed++; $display("FAIL parity_0003: got %b want 0", oParity); end
    sb.delete();
    repeat (N*N + 2) @(negedge clk);
    $display("[TB] parity complete");
`else
    $display("[TB] parity feature not built");
`endif
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_stream();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
